// File: rtl/e203_subsys_console_mst.sv
`default_nettype none
// ============================================================================
// Module   : e203_subsys_console_mst
// Brief    : ICB initiator for the simulation console. Buffers a byte stream
//            in a small FIFO, writes each byte to CHAR_OUT (BASE_ADDR+0x4),
//            and on request, after the FIFO drains, writes 1 to SIM_CTRL
//            (BASE_ADDR+0x8) and parks in DONE.
// Options  : CONSOLE_MST_TIMEOUT_EN - response timeout counter (TIMEOUT_CYC)
// Revision : 1.0 - initial release
// ============================================================================
module e203_subsys_console_mst #(
  parameter logic [31:0] BASE_ADDR   = 32'h1000_0000,
  parameter int          FIFO_DEPTH  = 8,
  parameter int          TIMEOUT_CYC = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        char_valid_i,
  output logic        char_ready_o,
  input  logic [7:0]  char_data_i,
  input  logic        finish_req_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [7:0]  err_cnt_o,
  output logic        icb_cmd_valid,
  input  logic        icb_cmd_ready,
  output logic [31:0] icb_cmd_addr,
  output logic        icb_cmd_read,
  output logic [31:0] icb_cmd_wdata,
  output logic [3:0]  icb_cmd_wmask,
  input  logic        icb_rsp_valid,
  output logic        icb_rsp_ready,
  input  logic        icb_rsp_err
);

  localparam int          AW        = $clog2(FIFO_DEPTH);
  localparam logic [31:0] CHAR_ADDR = BASE_ADDR + 32'h4;
  localparam logic [31:0] SIM_ADDR  = BASE_ADDR + 32'h8;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_CMD     = 3'd1;
  localparam logic [2:0] S_RSP     = 3'd2;
  localparam logic [2:0] S_FIN_CMD = 3'd3;
  localparam logic [2:0] S_FIN_RSP = 3'd4;
  localparam logic [2:0] S_DONE    = 3'd5;

  logic [2:0]    state;
  logic [2:0]    state_nxt;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic          fin_pending;
  logic          wait_st;
  logic          rsp_acc;
  logic          timeout;
  logic          err_inc;

  assign full         = (count == (AW+1)'(FIFO_DEPTH));
  assign empty        = (count == '0);
  assign char_ready_o = !full && (state != S_DONE);
  assign push         = char_valid_i && char_ready_o;
  assign pop          = (state == S_CMD) && icb_cmd_ready;
  assign wait_st      = (state == S_RSP) || (state == S_FIN_RSP);
  assign busy_o       = !empty || ((state != S_IDLE) && (state != S_DONE));
  assign icb_cmd_read  = 1'b0;
  assign icb_rsp_ready = 1'b1;

  // A response is only taken in the cycle the command handshakes or while waiting for it
  assign rsp_acc = (((state == S_CMD) || (state == S_FIN_CMD)) && icb_cmd_ready && icb_rsp_valid)
                 || (wait_st && icb_rsp_valid);

`ifdef CONSOLE_MST_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  logic [TW-1:0] tmo_cnt;

  // Wait-cycle counter: restarts every time a wait state is entered
  always_ff @(posedge clk_i) begin
    if (rst_i || !wait_st) tmo_cnt <= '0;
    else                   tmo_cnt <= tmo_cnt + 1'b1;
  end

  // A response arriving on the last wait cycle wins over the timeout
  assign timeout = wait_st && !icb_rsp_valid && (tmo_cnt == TW'(TIMEOUT_CYC - 1));
`else
  assign timeout = 1'b0;
`endif

  assign err_inc = (rsp_acc && icb_rsp_err) || timeout;

  // Character storage; contents need no reset because count gates every read
  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= char_data_i;
  end

  // FIFO pointers and occupancy; simultaneous push and pop leave count unchanged
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (!push && pop) count <= count - 1'b1;
    end
  end

  // Sticky finish request, dropped once the finish write has completed
  always_ff @(posedge clk_i) begin
    if (rst_i || (state == S_DONE)) fin_pending <= 1'b0;
    else if (finish_req_i)          fin_pending <= 1'b1;
  end

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic; queued characters always go out before the finish write
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (!empty)           state_nxt = S_CMD;
        else if (fin_pending) state_nxt = S_FIN_CMD;
      end
      S_CMD: begin
        if (icb_cmd_ready) state_nxt = icb_rsp_valid ? S_IDLE : S_RSP;
      end
      S_RSP: begin
        if (icb_rsp_valid || timeout) state_nxt = S_IDLE;
      end
      S_FIN_CMD: begin
        if (icb_cmd_ready) state_nxt = icb_rsp_valid ? S_DONE : S_FIN_RSP;
      end
      S_FIN_RSP: begin
        if (icb_rsp_valid || timeout) state_nxt = S_DONE;
      end
      S_DONE:  state_nxt = S_DONE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Command outputs; the FIFO head cannot move until the CHAR command handshakes
  always_comb begin
    icb_cmd_valid = 1'b0;
    icb_cmd_addr  = CHAR_ADDR;
    icb_cmd_wdata = {24'h0, mem[rd_ptr]};
    icb_cmd_wmask = 4'b0001;
    case (state)
      S_CMD: icb_cmd_valid = 1'b1;
      S_FIN_CMD: begin
        icb_cmd_valid = 1'b1;
        icb_cmd_addr  = SIM_ADDR;
        icb_cmd_wdata = 32'h1;
        icb_cmd_wmask = 4'b1111;
      end
      default: icb_cmd_valid = 1'b0;
    endcase
  end

  // Registered done flag, set together with the entry into DONE
  always_ff @(posedge clk_i) begin
    if (rst_i) done_o <= 1'b0;
    else       done_o <= (state_nxt == S_DONE);
  end

  // Saturating error counter
  always_ff @(posedge clk_i) begin
    if (rst_i)                               err_cnt_o <= 8'h00;
    else if (err_inc && (err_cnt_o != 8'hFF)) err_cnt_o <= err_cnt_o + 8'h01;
  end

endmodule
`default_nettype wire

// File: tb/tb_e203_subsys_console_mst.sv
`default_nettype none
// ============================================================================
// Module   : tb_e203_subsys_console_mst
// Brief    : Self-checking bench for e203_subsys_console_mst. A queue-based
//            model predicts every ICB write, FIFO readiness, done and the
//            saturating error count; the responder has a configurable latency.
// Revision : 1.0 - initial release
// ============================================================================
module tb_e203_subsys_console_mst;

  localparam logic [31:0] CHAR_A = 32'h1000_0004;
  localparam logic [31:0] SIM_A  = 32'h1000_0008;
  localparam int          DEPTH  = 8;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        char_valid_i;
  logic        char_ready_o;
  logic [7:0]  char_data_i;
  logic        finish_req_i;
  logic        busy_o;
  logic        done_o;
  logic [7:0]  err_cnt_o;
  logic        icb_cmd_valid;
  wire         icb_cmd_ready;
  logic [31:0] icb_cmd_addr;
  logic        icb_cmd_read;
  logic [31:0] icb_cmd_wdata;
  logic [3:0]  icb_cmd_wmask;
  wire         icb_rsp_valid;
  logic        icb_rsp_ready;
  logic        icb_rsp_err = 1'b0;

  // Responder configuration (written by the stimulus process only)
  int   lat      = 0;
  int   err_pct  = 0;
  logic rdy_rand = 1'b0;
  logic rdy_fix  = 1'b1;
  logic rdy_r    = 1'b0;

  // Responder / model state (written by the monitor only)
  int          pend      = 0;
  logic        dly_pulse = 1'b0;
  logic        stale     = 1'b0;
  logic [7:0]  q[$];
  int          occ       = 0;
  bit          model_done = 1'b0;
  bit          fin_req   = 1'b0;
  bit          fin_out   = 1'b0;
  int          exp_err   = 0;
  int          n_char    = 0;
  int          n_fin     = 0;
  int          cyc       = 0;
  int          last_hs   = 0;
  int          prev_hs   = 0;

  int checks = 0;
  int errors = 0;

  e203_subsys_console_mst #(
    .BASE_ADDR   (32'h1000_0000),
    .FIFO_DEPTH  (DEPTH),
    .TIMEOUT_CYC (10)
  ) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .char_valid_i  (char_valid_i),
    .char_ready_o  (char_ready_o),
    .char_data_i   (char_data_i),
    .finish_req_i  (finish_req_i),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .err_cnt_o     (err_cnt_o),
    .icb_cmd_valid (icb_cmd_valid),
    .icb_cmd_ready (icb_cmd_ready),
    .icb_cmd_addr  (icb_cmd_addr),
    .icb_cmd_read  (icb_cmd_read),
    .icb_cmd_wdata (icb_cmd_wdata),
    .icb_cmd_wmask (icb_cmd_wmask),
    .icb_rsp_valid (icb_rsp_valid),
    .icb_rsp_ready (icb_rsp_ready),
    .icb_rsp_err   (icb_rsp_err)
  );

  always #5 clk_i = ~clk_i;

  assign icb_cmd_ready = rdy_rand ? rdy_r : rdy_fix;
  assign icb_rsp_valid = (lat == 0) ? (icb_cmd_valid && icb_cmd_ready) : dly_pulse;

  always @(posedge clk_i) cyc++;

  always @(posedge clk_i) begin
    #1;
    rdy_r = ($urandom_range(3) != 0);
  end

  task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Responder and reference model, evaluated on the falling edge so every
  // value seen here is what the DUT samples on the following rising edge.
  always @(negedge clk_i) begin : mon
    logic hs;
    logic rv;
    dly_pulse = 1'b0;
    if (pend > 0) begin
      pend--;
      if (pend == 0) dly_pulse = 1'b1;
    end
    icb_rsp_err = ($urandom_range(99) < err_pct);
    hs = icb_cmd_valid && icb_cmd_ready;
    rv = (lat == 0) ? hs : dly_pulse;
    if (rst_i) begin
      q.delete();
      occ = 0; model_done = 1'b0; fin_req = 1'b0; fin_out = 1'b0; exp_err = 0;
      stale = (pend > 0);
    end else begin
      check("char_ready", char_ready_o, (occ < DEPTH) && !model_done);
      check("done", done_o, model_done);
      if (icb_cmd_valid && (pend > 0 || dly_pulse)) check("cmd_while_outstanding", 1, 0);
      if (hs) begin
        prev_hs = last_hs;
        last_hs = cyc;
        if (model_done) check("cmd_after_done", 1, 0);
        else if (q.size() != 0) begin
          check("char_cmd", {icb_cmd_read, icb_cmd_addr, icb_cmd_wdata, icb_cmd_wmask},
                {1'b0, CHAR_A, 24'h0, q[0], 4'h1});
          void'(q.pop_front());
          occ--;
          n_char++;
        end else if (fin_req) begin
          check("fin_cmd", {icb_cmd_read, icb_cmd_addr, icb_cmd_wdata, icb_cmd_wmask},
                {1'b0, SIM_A, 32'h1, 4'hF});
          fin_req = 1'b0;
          fin_out = 1'b1;
          n_fin++;
        end else check("unexpected_cmd", 1, 0);
        if (lat > 0) pend = lat;
      end
      if (rv) begin
        if (stale) stale = 1'b0;
        else begin
          if (icb_rsp_err && exp_err < 255) exp_err++;
          if (fin_out) begin
            model_done = 1'b1;
            fin_out = 1'b0;
          end
        end
      end
      if (char_valid_i && char_ready_o) begin
        q.push_back(char_data_i);
        occ++;
      end
      if (finish_req_i && !model_done) fin_req = 1'b1;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic push(input logic [7:0] b);
    int n = 0;
    char_valid_i = 1'b1;
    char_data_i  = b;
    @(negedge clk_i);
    while (!char_ready_o && n < 500) begin
      @(negedge clk_i);
      n++;
    end
    if (n >= 500) check("push_timeout", 1, 0);
    @(posedge clk_i);
    #1;
    char_valid_i = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk_i);
    while ((q.size() != 0 || pend != 0 || dly_pulse || icb_cmd_valid || fin_req || fin_out || busy_o)
           && n < 3000) begin
      @(negedge clk_i);
      n++;
    end
    if (n >= 3000) check("idle_timeout", 1, 0);
    tick(2);
  endtask

  task automatic wait_hs();
    int n = 0;
    @(negedge clk_i);
    while (pend == 0 && n < 200) begin
      @(negedge clk_i);
      n++;
    end
    if (n >= 200) check("hs_timeout", 1, 0);
    tick(1);
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    tick(2);
    rst_i = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int n0;
    int f0;
    int nb;
    rst_i = 1'b1; char_valid_i = 1'b0; char_data_i = 8'h00; finish_req_i = 1'b0;
    tick(3);
    @(negedge clk_i);
    check("rst_cmd_valid", icb_cmd_valid, 0);
    check("rst_done", done_o, 0);
    check("rst_err", err_cnt_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_char_ready", char_ready_o, 1);
    check("rsp_ready", icb_rsp_ready, 1);
    tick(1);
    rst_i = 1'b0;

    // "Hi" against a zero-latency responder: one write every 2 cycles
    n0 = n_char;
    push(8'h48);
    push(8'h69);
    wait_idle();
    check("hi_nchar", n_char - n0, 2);
    check("hi_gap", last_hs - prev_hs, 2);
    check("hi_err", err_cnt_o, 0);

    // Fill the FIFO with the command side stalled, then drain
    do_reset();
    rdy_fix = 1'b0;
    n0 = n_char;
    for (int i = 0; i < 8; i++) push(8'h30 + 8'(i));
    @(negedge clk_i);
    check("full_ready", char_ready_o, 0);
    tick(1);
    rdy_fix = 1'b1;
    push(8'h38);
    wait_idle();
    check("fill_nchar", n_char - n0, 9);

    // Finish request raised with the first of three characters
    do_reset();
    n0 = n_char;
    f0 = n_fin;
    finish_req_i = 1'b1;
    push(8'h41);
    finish_req_i = 1'b0;
    push(8'h42);
    push(8'h43);
    wait_idle();
    check("fin_nchar", n_char - n0, 3);
    check("fin_nfin", n_fin - f0, 1);
    check("fin_done", done_o, 1);
    check("fin_ready", char_ready_o, 0);
    finish_req_i = 1'b1;
    char_valid_i = 1'b1;
    tick(1);
    finish_req_i = 1'b0;
    tick(10);
    char_valid_i = 1'b0;
    check("done_nfin", n_fin - f0, 1);
    check("done_nchar", n_char - n0, 3);
    check("done_hold", done_o, 1);

    // Responses delayed by 5 cycles
    do_reset();
    lat = 5;
    n0 = n_char;
    push(8'h61);
    push(8'h62);
    push(8'h63);
    wait_idle();
    check("dly_nchar", n_char - n0, 3);
    check("dly_gap", last_hs - prev_hs, 7);

    // Randomised bursts with random ready, latency and error responses
    do_reset();
    rdy_rand = 1'b1;
    err_pct  = 30;
    for (int r = 0; r < 6; r++) begin
      lat = ($urandom_range(1) == 0) ? 0 : int'($urandom_range(3, 1));
      n0 = n_char;
      nb = int'($urandom_range(14, 4));
      for (int i = 0; i < nb; i++) begin
        push(8'($urandom_range(255)));
        tick(int'($urandom_range(2)));
      end
      wait_idle();
      check("rnd_nchar", n_char - n0, nb);
      check("rnd_err", err_cnt_o, exp_err);
      check("rnd_busy", busy_o, 0);
    end
    rdy_rand = 1'b0;

    // 300 error responses saturate the counter
    do_reset();
    lat = 0;
    err_pct = 100;
    for (int i = 0; i < 300; i++) push(8'(i));
    wait_idle();
    check("err_sat", err_cnt_o, exp_err);
    check("err_sat_ff", err_cnt_o, 8'hFF);

    // Reset while waiting for a response with 4 characters queued
    do_reset();
    lat = 5;
    rdy_fix = 1'b0;
    n0 = n_char;
    for (int i = 0; i < 5; i++) push(8'h70 + 8'(i));
    rdy_fix = 1'b1;
    wait_hs();
    rst_i = 1'b1;
    tick(1);
    rst_i = 1'b0;
    @(negedge clk_i);
    check("mid_rst_cmd_valid", icb_cmd_valid, 0);
    check("mid_rst_busy", busy_o, 0);
    check("mid_rst_ready", char_ready_o, 1);
    tick(8);
    check("late_rsp_err", err_cnt_o, 0);
    check("late_rsp_nchar", n_char - n0, 1);
    check("late_rsp_busy", busy_o, 0);

`ifdef CONSOLE_MST_TIMEOUT_EN
    // Silent responder: timeout after 10 wait cycles
    do_reset();
    lat = 50;
    err_pct = 0;
    push(8'h55);
    wait_hs();
    tick(13);
    check("tmo_err", err_cnt_o, 1);
    check("tmo_busy", busy_o, 0);
    check("tmo_cmd_valid", icb_cmd_valid, 0);
    wait_idle();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/e203_subsys_console_mst.md
Name: e203_subsys_console_mst

Overview:
ICB initiator that drives the simulation console responder. It accepts characters on a valid/ready byte stream, buffers them in a small FIFO, and issues one ICB write per character to the console CHAR_OUT register at BASE_ADDR+0x4. On request, once the FIFO has drained, it writes 1 to the SIM_CTRL register at BASE_ADDR+0x8 to end the simulation. Used as a test or boot-stub console driver where no CPU core is present.

Parameters:
BASE_ADDR, 32'h1000_0000, console base address; CHAR_OUT = BASE_ADDR+0x4, SIM_CTRL = BASE_ADDR+0x8
FIFO_DEPTH, 8, character FIFO depth; power of 2, minimum 2
TIMEOUT_CYC, 255, response timeout in cycles; used only with the optional feature

Ports:
clk_i  in  1  clock
rst_i  in  1  reset, synchronous, active-high
char_valid_i  in  1  character push valid
char_ready_o  out  1  FIFO can accept a character
char_data_i  in  8  character byte
finish_req_i  in  1  one-cycle pulse requesting SIM_CTRL finish after drain
busy_o  out  1  FIFO non-empty, or FSM not in IDLE/DONE
done_o  out  1  finish write completed
err_cnt_o  out  8  saturating count of error responses (and timeouts, if enabled)
icb_cmd_valid  out  1  ICB command valid
icb_cmd_ready  in  1  ICB command ready
icb_cmd_addr  out  32  ICB address
icb_cmd_read  out  1  always 0 (write only)
icb_cmd_wdata  out  32  write data
icb_cmd_wmask  out  4  byte mask
icb_rsp_valid  in  1  response valid
icb_rsp_ready  out  1  constant 1
icb_rsp_err  in  1  response error

Behaviour:
- Reset (rst_i=1 at a clk_i edge): FIFO emptied; FSM=IDLE; finish_pending=0; err_cnt_o=0; done_o=0; icb_cmd_valid=0. Reset mid-transaction abandons the transaction; any late response is ignored.
- FIFO: char_ready_o = !full && state!=DONE, a function of state only. A push happens when char_valid_i && char_ready_o. A pop happens on the command handshake of a CHAR write. Push and pop in the same cycle are both performed; count is unchanged. Pointers wrap modulo FIFO_DEPTH.
- finish_req_i sets finish_pending, which is sticky until DONE. A pulse while already DONE is ignored.
- FSM states: IDLE, CMD, RSP, FIN_CMD, FIN_RSP, DONE.
  - IDLE: FIFO non-empty -> CMD. Else if finish_pending -> FIN_CMD. Characters take priority over finish.
  - CMD: icb_cmd_valid=1, addr=BASE_ADDR+4, wdata={24'h0, FIFO head}, wmask=4'b0001. Command fields are held stable until icb_cmd_ready.
    - On handshake: pop the FIFO.
    - If icb_rsp_valid is also high that cycle, the response is consumed (combinational responder) -> IDLE.
    - Otherwise -> RSP.
  - RSP: on icb_rsp_valid -> IDLE.
  - FIN_CMD: icb_cmd_valid=1, addr=BASE_ADDR+8, wdata=32'h1, wmask=4'b1111.
    - Handshake with rsp_valid in the same cycle -> DONE.
    - Handshake without rsp_valid -> FIN_RSP.
  - FIN_RSP: on icb_rsp_valid -> DONE.
  - DONE: terminal until reset. done_o=1, char_ready_o=0, no further ICB commands.
- At most one outstanding transaction. icb_rsp_valid outside an expected response cycle is ignored.
- icb_cmd_valid=0 in IDLE, RSP, FIN_RSP and DONE.
- Every accepted response with icb_rsp_err=1 increments err_cnt_o, saturating at 8'hFF.
- Minimum throughput, back-to-back characters against a zero-latency responder: one character per 2 cycles (CMD, IDLE).
- done_o is registered: it goes high the cycle after the finish response and then holds.

Optional Feature:
Macro CONSOLE_MST_TIMEOUT_EN.
- Defined: a cycle counter clears on entry to RSP or FIN_RSP. If it reaches TIMEOUT_CYC with no response, err_cnt_o increments (saturating) and the FSM exits as if a response arrived: RSP -> IDLE, FIN_RSP -> DONE. A response in the same cycle as the timeout counts as a response, not a timeout.
- Undefined: no counter; RSP and FIN_RSP wait indefinitely.

Test Plan:
1. Zero-latency responder (cmd_ready=1, rsp_valid=cmd_valid), push "Hi" (0x48, 0x69) -> two writes to 0x1000_0004 with wdata 0x48 then 0x69, wmask 0x1, 2 cycles apart; err_cnt_o=0.
2. Push 9 bytes back-to-back while cmd_ready=0 -> char_ready_o drops after the 8th push; release cmd_ready -> all 8 written in order, 9th accepted once space frees, total 9 writes.
3. Push 3 bytes, pulse finish_req_i on the first push cycle -> 3 CHAR writes, then one write to 0x1000_0008 with wdata=1, wmask=0xF; done_o=1; char_ready_o=0 afterwards.
4. Responder returns rsp_err=1 for 300 writes -> err_cnt_o saturates at 0xFF.
5. Responder with rsp_valid delayed 5 cycles -> cmd_valid stays low during RSP; next command issues only after the response.
6. Assert rst_i in RSP with 4 bytes queued -> next cycle cmd_valid=0, FIFO empty, busy_o=0; the late rsp_valid is ignored and err_cnt_o stays 0. With CONSOLE_MST_TIMEOUT_EN and TIMEOUT_CYC=10, no response -> err_cnt_o=1 after 10 cycles, FSM back in IDLE.
